// File: rtl/secuenciador_contador_pkg.sv
// Shared definitions for the sequencer/counter: FSM encoding, reset value, legal set.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   estado_t    - four-state FSM encoding (IDLE, RUN, PAUSE, DONE)
//   Q_RESET     - counter value forced while reset is asserted
//   LEGAL_MASK  - one bit per 4-bit value, set when that value is on the cycle
//   es_legal()  - membership test against LEGAL_MASK
package secuenciador_contador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } estado_t;

    localparam logic [3:0] Q_RESET = 4'b0011;

    // Legal values: 0, 2, 3, 5, 8, 10, 11, 12, 13, 15.
    // Illegal values: 1, 4, 6, 7, 9, 14.
    localparam logic [15:0] LEGAL_MASK = 16'hBD2D;

    function automatic logic es_legal(input logic [3:0] v);
        return LEGAL_MASK[v];
    endfunction

endpackage

// File: rtl/secuenciador_contador_siguiente_estado.sv
// Combinational successor, display code and legality flag for a counter value.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow q_i continuously.
//
// Ports:
//   q_i      in  4  current counter value
//   q_sig_o  out 4  value one position further along the cycle
//   disp_o   out 4  display code of q_i
//   legal_o  out 1  q_i belongs to the cycle
module siguiente_estado
    import secuenciador_contador_pkg::*;
(
    input  logic [3:0] q_i,
    output logic [3:0] q_sig_o,
    output logic [3:0] disp_o,
    output logic       legal_o
);

    // Cycle: 3 -> 5 -> 0 -> 11 -> 10 -> 15 -> 2 -> 8 -> 12 -> 13 -> 3.
    // Off-cycle values fall back to the reset value so a corrupted
    // counter rejoins the cycle on its next advance.
    always_comb begin
        q_sig_o = Q_RESET;
        unique case (q_i)
            4'd3:    q_sig_o = 4'd5;
            4'd5:    q_sig_o = 4'd0;
            4'd0:    q_sig_o = 4'd11;
            4'd11:   q_sig_o = 4'd10;
            4'd10:   q_sig_o = 4'd15;
            4'd15:   q_sig_o = 4'd2;
            4'd2:    q_sig_o = 4'd8;
            4'd8:    q_sig_o = 4'd12;
            4'd12:   q_sig_o = 4'd13;
            4'd13:   q_sig_o = 4'd3;
            default: q_sig_o = Q_RESET;
        endcase
    end

    // Display folds 10 and 15 onto 11 and 13 onto 5; everything else passes.
    always_comb begin
        disp_o = q_i;
        case (q_i)
            4'd10, 4'd15: disp_o = 4'd11;
            4'd13:        disp_o = 4'd5;
            default:      disp_o = q_i;
        endcase
    end

    assign legal_o = es_legal(q_i);

endmodule

// File: rtl/secuenciador_contador.sv
// Sequencer that walks a 10-value cycle for a programmed number of advances.
// Latency: start sampled at edge k, first advance at k+1, done pulse after edge k+N.
// Backpressure: hold freezes the run (PAUSE); stop aborts; start/load ignored while busy or done.
//
// Ports:
//   C         in  1  clock, rising edge
//   nR        in  1  asynchronous active-low reset
//   start     in  1  begin a run (IDLE only)
//   stop      in  1  abort a run (RUN/PAUSE)
//   hold      in  1  freeze the run while high
//   load      in  1  load load_val into Q (IDLE only, wins over start)
//   load_val  in  4  value to load; off-cycle values load 3 and set err
//   steps     in  4  advances per run; 0 runs until stop
//   Q         out 4  counter value
//   I         out 4  display code of Q
//   busy      out 1  RUN or PAUSE
//   done      out 1  single-cycle pulse in DONE
//   err       out 1  sticky illegal-load flag
//   vueltas   out 4  completed cycles (13 -> 3 advances), modulo 16
module secuenciador_contador
    import secuenciador_contador_pkg::*;
(
    input  logic       C,
    input  logic       nR,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [3:0] steps,
    output logic [3:0] Q,
    output logic [3:0] I,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] vueltas
);

    estado_t    state_q, state_d;
    logic [3:0] q_q, q_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] vueltas_q, vueltas_d;
    logic       err_q, err_d;

    logic [3:0] q_sig;
    logic [3:0] disp;
    logic       q_legal;

    siguiente_estado u_siguiente_estado (
        .q_i     (q_q),
        .q_sig_o (q_sig),
        .disp_o  (disp),
        .legal_o (q_legal)
    );

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state_q   <= ST_IDLE;
            q_q       <= Q_RESET;
            rem_q     <= 4'd0;
            vueltas_q <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            rem_q     <= rem_d;
            vueltas_q <= vueltas_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        rem_d     = rem_q;
        vueltas_d = vueltas_q;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                // load has priority over start when both are high.
                if (load) begin
                    if (es_legal(load_val)) begin
                        q_d   = load_val;
                        err_d = 1'b0;
                    end else begin
                        q_d   = Q_RESET;
                        err_d = 1'b1;
                    end
                end else if (start) begin
                    state_d   = ST_RUN;
                    rem_d     = steps;
                    vueltas_d = 4'd0;
                    err_d     = 1'b0;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (hold) begin
                    state_d = ST_PAUSE;
                end else begin
                    q_d = q_legal ? q_sig : Q_RESET;
                    if (q_q == 4'd13) begin
                        vueltas_d = vueltas_q + 4'd1;
                    end
                    // rem_q == 0 at this point means a continuous run:
                    // it is never decremented and never reaches DONE.
                    if (rem_q != 4'd0) begin
                        rem_d = rem_q - 4'd1;
                        if (rem_q == 4'd1) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Q       = q_q;
    assign I       = disp;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    assign vueltas = vueltas_q;

endmodule
